switch_debouncer: RTL and testbench
===================================

# switch_debouncer

- Conditions raw Basys 3 slide-switch and push-button inputs into clean, stable logic levels.
- Sits directly upstream of the combinational gate blocks: the debounced outputs drive the gate operand inputs, and the edge pulses are available to downstream counters and LED logic.
- For each channel it synchronises the asynchronous pad signal into the clock domain, then accepts a level change only after the signal has held steady for a programmable number of cycles.
- On each accepted change it emits a one-cycle rise or fall pulse.

## Interface

Parameters:
- N_CH, 2, number of independent input channels.
- CNT_MAX, 1000000, number of consecutive stable cycles required to accept a change (10 ms at 100 MHz). Legal range is ≥ 2.

Ports:
- clk  in  1  system clock, 100 MHz on the board.
- rst  in  1  reset, synchronous and active-high.
- raw_in  in  N_CH  asynchronous switch/button levels.
- db_out  out  N_CH  debounced level per channel.
- rise  out  N_CH  one-cycle pulse when db_out goes 0→1.
- fall  out  N_CH  one-cycle pulse when db_out goes 1→0.

## Operation

- Each channel is fully independent. No shared state exists between channels.
- Synchroniser: two flops, sync1 ← raw_in and s ← sync1. The state machine sees only s.
- State machine per channel has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if s=1, go to WAIT_HI and load cnt=0. Otherwise hold.
  - WAIT_HI: if s=0, return to STABLE_LO (glitch rejected; db_out unchanged). Otherwise, if cnt=CNT_MAX-1, go to STABLE_HI, set db_out=1 and pulse rise. Otherwise cnt++.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted. Acceptance sets db_out=0 and pulses fall.
- Counter rules:
  - Width is $clog2(CNT_MAX).
  - The counter never wraps: it stops at CNT_MAX-1 because acceptance occurs there.
  - The counter is only meaningful in the WAIT states.
- Pulses:
  - rise and fall are registered.
  - Each is high for exactly one cycle, in the same cycle db_out takes its new value.
  - rise and fall are never both high on the same channel.
- Any bounce during a WAIT state restarts the qualification: a return to the stable state followed by a fresh WAIT entry.
- A level that toggles faster than CNT_MAX cycles is never accepted. db_out holds its last accepted value indefinitely.

## Timing

- Reset values:
  - sync1 = 0 and s = 0.
  - state = STABLE_LO and cnt = 0.
  - db_out = 0, rise = 0, fall = 0.
- Reset is sampled on the clk edge only and overrides all other activity, including reset mid-WAIT or in the pulse cycle.
- A raw input that is held high through reset is re-qualified from STABLE_LO after reset releases. It produces a rise after the full latency.
- Latency: a raw change captured at edge E0 gives db_out and the pulse changing after edge E0+CNT_MAX+2.
  - Breakdown: 2 synchroniser edges, 1 WAIT entry edge, then CNT_MAX-1 count edges plus the acceptance edge.
- Minimum accepted pulse width: s must stay at the new level for CNT_MAX+1 consecutive cycles, counted from the WAIT entry edge through the acceptance edge.

## Structure

- Shared package debounce_pkg holds:
  - the state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, 2-bit encoding);
  - the default CNT_MAX constant;
  - a simulation constant CNT_MAX_SIM = 4.
- Sub-module debounce_channel contains the synchroniser, counter and FSM for one bit.
- The top level switch_debouncer is a generate loop of N_CH instances.

## Test plan

All scenarios use CNT_MAX=4.

- Reset and idle: assert rst for 3 cycles with raw_in=2'b00, then release and hold for 20 cycles. db_out=00 and rise=fall=00 throughout.
- Clean press: raw_in[0] goes 0→1 at edge E0 and holds. db_out[0]=1 and rise[0]=1 after edge E0+6. rise[0] is 0 one cycle later. fall stays 0.
- Bounce rejection: raw_in[1] toggles 1,0,1,0 with each level lasting 2 cycles, then settles to 1. db_out[1] stays 0 until 6 edges after the final 0→1 capture. Exactly one rise[1] pulse occurs.
- Release: with db_out[0]=1, raw_in[0] goes 1→0 at E0. db_out[0]=0 and fall[0]=1 after E0+6. There is a single pulse.
- Independence and simultaneity: both channels change at the same edge in opposite directions (0→1 on ch0, 1→0 on ch1 from a settled state). rise[0] and fall[1] assert in the same cycle, with no cross-effects.
- Reset mid-WAIT: raw_in[0]=1 for 3 cycles, then rst is pulsed for 1 cycle. State returns to STABLE_LO and db_out[0] stays 0. A rise appears only 6 edges after the post-reset sync re-captures 1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch/button debouncer: FSM state encoding and
// qualification-length constants.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } db_state_e;

   // 10 ms at 100 MHz
   localparam int CNT_MAX_DEFAULT = 1000000;
   localparam int CNT_MAX_SIM     = 4;

   // Counter width needed to hold 0 .. cnt_max-1.
   function automatic int cnt_width(input int cnt_max);
      return (cnt_max < 2) ? 1 : $clog2(cnt_max);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter and a
// four-state acceptance FSM producing a clean level plus rise/fall pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// STABLE_LO | db_out = 0, synchronised input agrees
// WAIT_HI   | input seen high, counting stable cycles before accepting 1
// STABLE_HI | db_out = 1, synchronised input agrees
// WAIT_LO   | input seen low, counting stable cycles before accepting 0
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic db_out,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   localparam logic [1:0] ST_STABLE_LO = 2'(STABLE_LO);
   localparam logic [1:0] ST_WAIT_HI   = 2'(WAIT_HI);
   localparam logic [1:0] ST_STABLE_HI = 2'(STABLE_HI);
   localparam logic [1:0] ST_WAIT_LO   = 2'(WAIT_LO);

   logic          sync1;
   logic          s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         s      <= 1'b0;
         state  <= ST_STABLE_LO;
         cnt    <= '0;
         db_out <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync1 <= raw_in;
         s     <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         case (state)
            ST_STABLE_LO: begin
               if (s) begin
                  state <= ST_WAIT_HI;
                  cnt   <= '0;
               end
            end
            ST_WAIT_HI: begin
               // a low sample here is a bounce: drop back and requalify later
               if (!s) begin
                  state <= ST_STABLE_LO;
               end else if (cnt == CNT_LAST) begin
                  state  <= ST_STABLE_HI;
                  db_out <= 1'b1;
                  rise   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STABLE_HI: begin
               if (!s) begin
                  state <= ST_WAIT_LO;
                  cnt   <= '0;
               end
            end
            ST_WAIT_LO: begin
               if (s) begin
                  state <= ST_STABLE_HI;
               end else if (cnt == CNT_LAST) begin
                  state  <= ST_STABLE_LO;
                  db_out <= 1'b0;
                  fall   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_STABLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Debouncer for N_CH independent board switches/buttons; each bit gets its
// own synchroniser, counter and FSM with no shared state.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .CNT_MAX(CNT_MAX)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .raw_in (raw_in[i]),
         .db_out (db_out[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with CNT_MAX = 4, checked each cycle
// against a run-length model plus hand-computed expectations.
module tb_switch_debouncer;

   localparam int N_CH = 2;
   localparam int CM   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] raw_in;
   logic [N_CH-1:0] db_out;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;

   always #5 clk = ~clk;

   switch_debouncer #(
      .N_CH    (N_CH),
      .CNT_MAX (CM)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_in),
      .db_out (db_out),
      .rise   (rise),
      .fall   (fall)
   );

   int checks = 0;
   int errors = 0;

   // Model: db flips once the synchronised level has differed from it for
   // CM+1 consecutive edges; any agreeing sample resets the run.
   logic [N_CH-1:0] m_sync1 = '0;
   logic [N_CH-1:0] m_s     = '0;
   logic [N_CH-1:0] m_db    = '0;
   logic [N_CH-1:0] m_rise  = '0;
   logic [N_CH-1:0] m_fall  = '0;
   int              m_run [N_CH];
   bit              m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_sync1 = '0;
         m_s     = '0;
         m_db    = '0;
         m_rise  = '0;
         m_fall  = '0;
         for (int c = 0; c < N_CH; c++) m_run[c] = 0;
         m_valid = 1'b1;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (m_s[c] != m_db[c]) begin
               m_run[c] = m_run[c] + 1;
               if (m_run[c] == CM + 1) begin
                  m_db[c] = m_s[c];
                  if (m_s[c]) m_rise[c] = 1'b1;
                  else        m_fall[c] = 1'b1;
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_s     = m_sync1;
         m_sync1 = raw_in;
      end
   end

   int n_rise [N_CH];
   int n_fall [N_CH];

   initial begin
      for (int c = 0; c < N_CH; c++) begin
         n_rise[c] = 0;
         n_fall[c] = 0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checks = checks + 3;
         if (db_out !== m_db) begin
            errors++;
            $display("FAIL model_db t=%0t got %b want %b", $time, db_out, m_db);
         end
         if (rise !== m_rise) begin
            errors++;
            $display("FAIL model_rise t=%0t got %b want %b", $time, rise, m_rise);
         end
         if (fall !== m_fall) begin
            errors++;
            $display("FAIL model_fall t=%0t got %b want %b", $time, fall, m_fall);
         end
         for (int c = 0; c < N_CH; c++) begin
            if (rise[c] === 1'b1) n_rise[c]++;
            if (fall[c] === 1'b1) n_fall[c]++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [N_CH-1:0] act,
                      input logic [N_CH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   int base;

   initial begin
      rst    = 1'b1;
      raw_in = 2'b00;
      tick(3);
      rst = 1'b0;
      tick(20);
      chk("idle_db", db_out, 2'b00);
      chk("idle_rise", rise, 2'b00);
      chk("idle_fall", fall, 2'b00);
      chk_int("idle_no_pulses", n_rise[0] + n_rise[1] + n_fall[0] + n_fall[1], 0);

      // clean press on ch0
      raw_in[0] = 1'b1;
      tick(6);
      chk("press_before_accept", db_out, 2'b00);
      tick(1);
      chk("press_db", db_out, 2'b01);
      chk("press_rise", rise, 2'b01);
      chk("press_fall", fall, 2'b00);
      tick(1);
      chk("press_rise_end", rise, 2'b00);

      // bounce on ch1: 1,0,1,0 two cycles each, then settle high
      base = n_rise[1];
      for (int k = 0; k < 4; k++) begin
         raw_in[1] = (k % 2 == 0);
         tick(2);
      end
      chk("bounce_rejected", db_out, 2'b01);
      raw_in[1] = 1'b1;
      tick(6);
      chk("bounce_before_accept", db_out, 2'b01);
      tick(1);
      chk("bounce_db", db_out, 2'b11);
      chk("bounce_rise", rise, 2'b10);
      tick(10);
      chk_int("bounce_single_rise", n_rise[1] - base, 1);

      // release ch0
      base = n_fall[0];
      raw_in[0] = 1'b0;
      tick(6);
      chk("release_before_accept", db_out, 2'b11);
      tick(1);
      chk("release_db", db_out, 2'b10);
      chk("release_fall", fall, 2'b01);
      chk("release_rise", rise, 2'b00);
      tick(10);
      chk_int("release_single_fall", n_fall[0] - base, 1);

      // opposite transitions on both channels at the same edge
      raw_in = 2'b01;
      tick(6);
      chk("simul_before_accept", db_out, 2'b10);
      tick(1);
      chk("simul_db", db_out, 2'b01);
      chk("simul_rise", rise, 2'b01);
      chk("simul_fall", fall, 2'b10);
      tick(1);
      chk("simul_pulses_end", rise | fall, 2'b00);

      // reset in the middle of WAIT_HI
      raw_in = 2'b00;
      tick(12);
      chk("pre_midwait_db", db_out, 2'b00);
      raw_in[0] = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midwait_reset_db", db_out, 2'b00);
      tick(6);
      chk("midwait_before_accept", db_out, 2'b00);
      tick(1);
      chk("midwait_db", db_out, 2'b01);
      chk("midwait_rise", rise, 2'b01);

      // reset landing on what would be the fall acceptance edge
      base = n_fall[0];
      raw_in[0] = 1'b0;
      tick(6);
      rst = 1'b1;
      tick(1);
      chk("pulse_reset_fall", fall, 2'b00);
      chk("pulse_reset_db", db_out, 2'b00);
      rst = 1'b0;
      tick(10);
      chk_int("pulse_reset_no_fall", n_fall[0] - base, 0);

      // inputs held high through reset are requalified from STABLE_LO
      raw_in = 2'b11;
      tick(20);
      chk("held_pre_db", db_out, 2'b11);
      rst = 1'b1;
      tick(3);
      chk("held_reset_db", db_out, 2'b00);
      rst = 1'b0;
      tick(6);
      chk("held_before_accept", db_out, 2'b00);
      tick(1);
      chk("held_db", db_out, 2'b11);
      chk("held_rise", rise, 2'b11);
      tick(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
